// File: rtl/mem_stage_sram_pkg.sv
// Shared definitions for the SRAM-backed memory stage: FSM state encoding,
// default address map / SRAM geometry and data-path widths.
package mem_stage_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] MEM_BASE_DEF    = 32'd1024;
  localparam int unsigned SRAM_ADDR_W_DEF = 18;
  localparam int unsigned HALF_W          = 16;
  // Wide enough for the largest legal wait-state count (7).
  localparam int unsigned WAIT_W          = 3;

endpackage

// File: rtl/mem_stage_sram_if.sv
// External 16-bit asynchronous SRAM port. The memory stage drives it through
// the master modport; the SRAM (or its model) sits on the slave modport.
interface mem_stage_sram_if
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEF
) ();

  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [HALF_W-1:0]      sram_wdata;
  logic [HALF_W-1:0]      sram_rdata;
  logic                   sram_we_n;

  modport master (
    output sram_addr,
    output sram_wdata,
    output sram_we_n,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr,
    input  sram_wdata,
    input  sram_we_n,
    output sram_rdata
  );

endinterface

// File: rtl/mem_stage_sram_wait_counter.sv
// sram_wait_counter: loadable down-counter timing one SRAM half-word phase.
// Load wins over count; the counter stops at zero, where tc_o is asserted.
module sram_wait_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count register: load, decrement while enabled, hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: pipeline MEM stage backed by a 16-bit external SRAM.
// A 32-bit access is split into a LOW and a HIGH half-word phase, each
// WAIT_CYCLES+1 cycles long; the pipeline is frozen for the duration.
// Optional macro MEM_ALIGN_CHECK_EN: flags misaligned / below-base accesses
// in a sticky mem_fault, suppresses the store and returns 0 for the load.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] MEM_BASE    = MEM_BASE_DEF,
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_res,
  input  logic [31:0] val_Rm,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        wb_en,
  input  logic [3:0]  dest,
  output logic        freeze,
  output logic [31:0] MEM_wb_val,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic [3:0]  dest_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic        mem_fault,
  mem_stage_sram_if.master sram
);

  localparam int unsigned WORD_W = SRAM_ADDR_W - 1;

  state_e              state_q, state_d;
  logic                mem_op;
  logic                accept;
  logic                in_phase;
  logic                tc;
  logic                cnt_load;
  logic                op_fault;

  logic [WORD_W-1:0]   word_q;
  logic [31:0]         alu_q;
  logic [31:0]         val_q;
  logic                load_q;
  logic                store_q;
  logic                wb_q;
  logic [3:0]          dest_q;
  logic                fault_q;
  logic [HALF_W-1:0]   rd_lo_q;
  logic [HALF_W-1:0]   rd_hi_q;
  logic [31:0]         load_word;

  assign mem_op   = mem_read | mem_write;
  assign accept   = (state_q == IDLE) && mem_op;
  assign in_phase = (state_q == LOW) || (state_q == HIGH);

`ifdef MEM_ALIGN_CHECK_EN
  logic mem_fault_q;

  assign op_fault = mem_op && ((ALU_res[1:0] != 2'b00) || (ALU_res < MEM_BASE));

  // Sticky fault flag, set when a faulting access is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_fault_q <= 1'b0;
    end else if (accept && op_fault) begin
      mem_fault_q <= 1'b1;
    end
  end

  assign mem_fault = mem_fault_q;
`else
  assign op_fault  = 1'b0;
  assign mem_fault = 1'b0;
`endif

  sram_wait_counter #(
    .WIDTH (WAIT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (cnt_load),
    .load_val_i (WAIT_W'(WAIT_CYCLES)),
    .en_i       (in_phase),
    .tc_o       (tc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter reload and pipeline freeze.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    freeze   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d  = LOW;
          cnt_load = 1'b1;
          freeze   = 1'b1;
        end
      end
      LOW: begin
        freeze = 1'b1;
        if (tc) begin
          state_d  = HIGH;
          cnt_load = 1'b1;
        end
      end
      HIGH: begin
        freeze = 1'b1;
        if (tc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the memory instruction when it is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q  <= '0;
      alu_q   <= '0;
      val_q   <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      wb_q    <= 1'b0;
      dest_q  <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      word_q  <= WORD_W'((ALU_res - MEM_BASE) >> 2);
      alu_q   <= ALU_res;
      val_q   <= val_Rm;
      load_q  <= mem_read;
      store_q <= mem_write & ~mem_read;
      wb_q    <= wb_en;
      dest_q  <= dest;
      fault_q <= op_fault;
    end
  end

  // Sample read half-words on the last cycle of each phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_lo_q <= '0;
      rd_hi_q <= '0;
    end else begin
      if ((state_q == LOW) && tc) begin
        rd_lo_q <= sram.sram_rdata;
      end
      if ((state_q == HIGH) && tc) begin
        rd_hi_q <= sram.sram_rdata;
      end
    end
  end

  // SRAM outputs derive only from registers, so they are stable for a whole
  // phase; write enable is released on the final (tc) cycle of each phase.
  assign sram.sram_addr  = {word_q, (state_q == HIGH)};
  assign sram.sram_wdata = (state_q == HIGH) ? val_q[31:16] : val_q[15:0];
  assign sram.sram_we_n  = ~(in_phase && store_q && !fault_q && !tc);

  assign load_word  = fault_q ? '0 : {rd_hi_q, rd_lo_q};
  assign MEM_wb_val = ((state_q == DONE) && load_q) ? load_word : ALU_res;

  // MEM/WB register: result at DONE, bubble while frozen, else pass-through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out    <= 1'b0;
      mem_read_out <= 1'b0;
      dest_out     <= '0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
    end else if (state_q == DONE) begin
      wb_en_out    <= wb_q;
      mem_read_out <= load_q;
      dest_out     <= dest_q;
      alu_res_out  <= alu_q;
      mem_data_out <= load_q ? load_word : '0;
    end else if (freeze) begin
      wb_en_out    <= 1'b0;
      mem_read_out <= 1'b0;
    end else begin
      wb_en_out    <= wb_en;
      mem_read_out <= 1'b0;
      dest_out     <= dest;
      alu_res_out  <= ALU_res;
      mem_data_out <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with a 16-entry behavioural SRAM.
// Expectations follow MEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_mem_stage_sram;
  import mem_stage_sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALU_res, val_Rm;
  logic        mem_read, mem_write, wb_en;
  logic [3:0]  dest;
  logic        freeze, wb_en_out, mem_read_out, mem_fault;
  logic [31:0] MEM_wb_val, alu_res_out, mem_data_out;
  logic [3:0]  dest_out;

  int checks = 0;
  int errors = 0;
  int fc, wc;

  logic [15:0] mem [16];

  mem_stage_sram_if #(.SRAM_ADDR_W(18)) sram_bus ();

  mem_stage_sram #(
    .WAIT_CYCLES (1),
    .MEM_BASE    (32'd1024),
    .SRAM_ADDR_W (18)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ALU_res      (ALU_res),
    .val_Rm       (val_Rm),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .wb_en        (wb_en),
    .dest         (dest),
    .freeze       (freeze),
    .MEM_wb_val   (MEM_wb_val),
    .wb_en_out    (wb_en_out),
    .mem_read_out (mem_read_out),
    .dest_out     (dest_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out),
    .mem_fault    (mem_fault),
    .sram         (sram_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_bus.sram_we_n) mem[sram_bus.sram_addr[3:0]] <= sram_bus.sram_wdata;
  end
  assign sram_bus.sram_rdata = mem[sram_bus.sram_addr[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] v, input logic rd,
                       input logic wr, input logic wb, input logic [3:0] d);
    ALU_res = a; val_Rm = v; mem_read = rd; mem_write = wr; wb_en = wb; dest = d;
  endtask

  // Step through an accepted access until freeze drops (DONE), bounded.
  task automatic run_access(output int fcyc, output int wecyc);
    fcyc = 0;
    wecyc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!freeze) break;
      fcyc++;
      if (!sram_bus.sram_we_n) wecyc++;
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    #3;
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_wb_en_out", {31'd0, wb_en_out}, 32'd0);
    chk("rst_alu_res_out", alu_res_out, 32'd0);
    chk("rst_mem_data_out", mem_data_out, 32'd0);
    chk("rst_we_n", {31'd0, sram_bus.sram_we_n}, 32'd1);
    chk("rst_addr", {14'd0, sram_bus.sram_addr}, 32'd0);
    chk("rst_wdata", {16'd0, sram_bus.sram_wdata}, 32'd0);
    chk("rst_fault", {31'd0, mem_fault}, 32'd0);
    tick();
    tick();
    rst = 1'b1;

    // Plain ALU op passes straight through
    drive(32'h55, 32'd0, 1'b0, 1'b0, 1'b1, 4'd3);
    #1;
    chk("alu_freeze", {31'd0, freeze}, 32'd0);
    chk("alu_fwd", MEM_wb_val, 32'h55);
    tick();
    chk("alu_wb_en_out", {31'd0, wb_en_out}, 32'd1);
    chk("alu_dest_out", {28'd0, dest_out}, 32'd3);
    chk("alu_res_out", alu_res_out, 32'h55);
    chk("alu_freeze2", {31'd0, freeze}, 32'd0);

    // Store 0xDEADBEEF to 1028 -> half-words 2 and 3
    drive(32'd1028, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    chk("st_idle_freeze", {31'd0, freeze}, 32'd1);
    tick();
    chk("st_lo_addr", {14'd0, sram_bus.sram_addr}, 32'd2);
    chk("st_lo_wdata", {16'd0, sram_bus.sram_wdata}, 32'hBEEF);
    chk("st_lo_we1", {31'd0, sram_bus.sram_we_n}, 32'd0);
    chk("st_bubble", {31'd0, wb_en_out}, 32'd0);
    tick();
    chk("st_lo_we2", {31'd0, sram_bus.sram_we_n}, 32'd1);
    chk("st_lo_addr2", {14'd0, sram_bus.sram_addr}, 32'd2);
    chk("st_lo_freeze2", {31'd0, freeze}, 32'd1);
    tick();
    chk("st_hi_addr", {14'd0, sram_bus.sram_addr}, 32'd3);
    chk("st_hi_wdata", {16'd0, sram_bus.sram_wdata}, 32'hDEAD);
    chk("st_hi_we1", {31'd0, sram_bus.sram_we_n}, 32'd0);
    tick();
    chk("st_hi_we2", {31'd0, sram_bus.sram_we_n}, 32'd1);
    chk("st_hi_freeze2", {31'd0, freeze}, 32'd1);
    tick();
    chk("st_done_freeze", {31'd0, freeze}, 32'd0);
    chk("st_done_we", {31'd0, sram_bus.sram_we_n}, 32'd1);
    chk("st_done_fwd", MEM_wb_val, 32'd1028);
    drive(32'h77, 32'd0, 1'b0, 1'b0, 1'b1, 4'd9);
    tick();
    chk("st_wb_alu_res", alu_res_out, 32'd1028);
    chk("st_wb_en", {31'd0, wb_en_out}, 32'd0);
    chk("st_mem2", {16'd0, mem[2]}, 32'hBEEF);
    chk("st_mem3", {16'd0, mem[3]}, 32'hDEAD);
    tick();
    chk("alu2_wb_en_out", {31'd0, wb_en_out}, 32'd1);
    chk("alu2_res_out", alu_res_out, 32'h77);

    // Load from 1028 -> 0xDEADBEEF
    drive(32'd1028, 32'd0, 1'b1, 1'b0, 1'b1, 4'd5);
    #1;
    chk("ld_idle_freeze", {31'd0, freeze}, 32'd1);
    tick();
    chk("ld_bubble_wb", {31'd0, wb_en_out}, 32'd0);
    chk("ld_lo_addr", {14'd0, sram_bus.sram_addr}, 32'd2);
    chk("ld_lo_we", {31'd0, sram_bus.sram_we_n}, 32'd1);
    tick();
    tick();
    chk("ld_hi_addr", {14'd0, sram_bus.sram_addr}, 32'd3);
    chk("ld_hi_we", {31'd0, sram_bus.sram_we_n}, 32'd1);
    tick();
    tick();
    chk("ld_done_freeze", {31'd0, freeze}, 32'd0);
    chk("ld_done_fwd", MEM_wb_val, 32'hDEADBEEF);
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk("ld_mem_data_out", mem_data_out, 32'hDEADBEEF);
    chk("ld_mem_read_out", {31'd0, mem_read_out}, 32'd1);
    chk("ld_wb_en_out", {31'd0, wb_en_out}, 32'd1);
    chk("ld_dest_out", {28'd0, dest_out}, 32'd5);
    chk("ld_alu_res_out", alu_res_out, 32'd1028);

    // Misaligned store to 1030
    drive(32'd1030, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    run_access(fc, wc);
    chk("mis_st_freeze_cycles", fc, 32'd4);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_st_we_cycles", wc, 32'd0);
    chk("mis_st_fault", {31'd0, mem_fault}, 32'd1);
`else
    chk("mis_st_we_cycles", wc, 32'd2);
    chk("mis_st_fault", {31'd0, mem_fault}, 32'd0);
`endif
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_st_mem2", {16'd0, mem[2]}, 32'hBEEF);
`else
    chk("mis_st_mem2", {16'd0, mem[2]}, 32'hF00D);
`endif

    // Both mem bits high at 1031: treated as a load
    drive(32'd1031, 32'h0, 1'b1, 1'b1, 1'b1, 4'd7);
    #1;
    run_access(fc, wc);
    chk("rw_freeze_cycles", fc, 32'd4);
    chk("rw_we_cycles", wc, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("rw_done_fwd", MEM_wb_val, 32'd0);
`else
    chk("rw_done_fwd", MEM_wb_val, 32'hCAFEF00D);
`endif
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    chk("rw_mem_data_out", mem_data_out, 32'd0);
    chk("rw_fault_sticky", {31'd0, mem_fault}, 32'd1);
`else
    chk("rw_mem_data_out", mem_data_out, 32'hCAFEF00D);
    chk("rw_fault_sticky", {31'd0, mem_fault}, 32'd0);
`endif
    chk("rw_mem_read_out", {31'd0, mem_read_out}, 32'd1);

    // Reset during the second HIGH cycle of a store
    drive(32'd1032, 32'h12345678, 1'b0, 1'b1, 1'b1, 4'd2);
    tick();
    tick();
    tick();
    tick();
    chk("ab_hi_addr", {14'd0, sram_bus.sram_addr}, 32'd5);
    chk("ab_hi_freeze", {31'd0, freeze}, 32'd1);
    rst = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    #1;
    chk("ab_we_n", {31'd0, sram_bus.sram_we_n}, 32'd1);
    chk("ab_freeze", {31'd0, freeze}, 32'd0);
    chk("ab_wb_en_out", {31'd0, wb_en_out}, 32'd0);
    chk("ab_addr", {14'd0, sram_bus.sram_addr}, 32'd0);
    chk("ab_fault", {31'd0, mem_fault}, 32'd0);
    rst = 1'b1;
    tick();
    chk("ab_post_wb_en_out", {31'd0, wb_en_out}, 32'd0);
    chk("ab_post_alu_res_out", alu_res_out, 32'd0);
    chk("ab_post_freeze", {31'd0, freeze}, 32'd0);
    chk("ab_post_we_n", {31'd0, sram_bus.sram_we_n}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
